alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
- REQ-001: Parameter WIDTH, default 8, sets the data width of every operand and result.
- REQ-002: Parameter NCORE, default 4, sets the number of requesting cores; legal range is 2..8.
- REQ-003: Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
- REQ-004: Port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005: Port req, input, NCORE bits: per-core request, level-held until that core's done pulse.
- REQ-006: Port op, input, NCORE*4 bits: per-core one-hot op (SET 0001, MUL 0010, ADD 0100, ADDMEM 1000); core i occupies slice [4i+3:4i].
- REQ-007: Port ac, input, NCORE*WIDTH bits: per-core accumulator operand.
- REQ-008: Port bus_in, input, NCORE*WIDTH bits: per-core bus operand.
- REQ-009: Port mem_id, input, NCORE*WIDTH bits: per-core memory-ID operand.
- REQ-010: Port gnt, output, NCORE bits: one-hot grant, high from the capture cycle through the done cycle.
- REQ-011: Port done, output, NCORE bits: one-cycle completion pulse to the granted core.
- REQ-012: Port result, output, WIDTH bits: registered result, valid in the done cycle, held until the next done.
- REQ-013: Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
- REQ-014: The FSM states are IDLE, EXEC, MUL2 and DONE.
- REQ-015: IDLE with any req bit set: select a winner round-robin, starting the search at the core after the last winner; in the same edge, assert gnt, latch that core's op/ac/bus_in/mem_id, and go to EXEC.
- REQ-016: After reset, the round-robin search starts at core 0.
- REQ-017: EXEC, for SET/ADD/ADDMEM/invalid op: write result on this edge and go to DONE.
- REQ-018: EXEC, for MUL: go to MUL2; the product is registered on the MUL2 edge, after which the FSM goes to DONE.
- REQ-019: Result values: SET gives bus; MUL gives ac*bus; ADD gives ac+bus; ADDMEM gives ac+mem_id.
- REQ-020: All arithmetic results are truncated to the low WIDTH bits; no carry or overflow flag is produced.
- REQ-021: An op that is not exactly one-hot (zero or multi-bit) is treated as pass-through: result equals the latched ac.
- REQ-022: Latency from grant edge to done pulse is 2 cycles for non-MUL ops and 3 cycles for MUL.
- REQ-023: DONE: pulse done for the granted core for one cycle, update the last-winner pointer, deassert gnt, and return to IDLE.
- REQ-024: Back-to-back transactions are separated by exactly one IDLE cycle.
- REQ-025: Operands are latched at grant; requester input changes after grant have no effect on the transaction.
- REQ-026: A req deasserted mid-transaction does not abort it; done still pulses.
- REQ-027: Simultaneous requests: exactly one grant is issued; no core is granted twice while another core requests continuously.
- REQ-028: A core whose req is still high after its done competes again in round-robin order.

Reset
- REQ-029: rst_n low asynchronously forces: state IDLE, gnt 0, done 0, result 0, busy 0, last-winner pointer to core NCORE-1.
- REQ-030: Reset asserted mid-transaction abandons the transaction with no done pulse; after reset release, arbitration restarts at core 0.

Structure
- REQ-031: Op encodings and FSM state constants live in shared package alu_pkg.
- REQ-032: The round-robin selection is a separate sub-module rr_pick: inputs req and pointer, output a one-hot winner, purely combinational.

Verification
- REQ-033: Single request, core 2 ADD with ac=0x05, bus_in=0x03 -> gnt=0100 for 2 cycles, done[2] pulses at grant+2, result=0x08.
- REQ-034: Core 0 MUL with ac=0x10, bus_in=0x11 -> done at grant+3, result=0x10 (truncated from 0x110).
- REQ-035: All four cores request continuously, starting after reset -> grant order 0,1,2,3,0 with one IDLE cycle between transactions.
- REQ-036: Core 1 ADDMEM with ac=0xFF, mem_id=0x02 -> result=0x01; op=0011 with ac=0x5A -> result=0x5A.
- REQ-037: rst_n pulsed low during MUL2 -> outputs 0 immediately, no done pulse; next grant goes to the lowest requesting core from 0.
- REQ-038: Core 3 changes bus_in one cycle after its grant -> result uses the originally latched bus_in value.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants for the shared-ALU arbiter: one-hot op encodings and
// FSM state codes. Imported by alu_share_arbiter.
package alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_SET    = 4'b0001;
    localparam op_t OP_MUL    = 4'b0010;
    localparam op_t OP_ADD    = 4'b0100;
    localparam op_t OP_ADDMEM = 4'b1000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL2 = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin selector. The search begins at the core after
// the last winner and wraps around.
// Ports:
//   req  - per-core request vector
//   ptr  - index of the last winner
//   win  - one-hot winner (all zero when no request is pending)
module rr_pick #(
    parameter int NCORE = 4,
    parameter int PW    = $clog2(NCORE)
) (
    input  logic [NCORE-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NCORE-1:0] win
);

    logic found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        // Offset k=1 is the core right after the last winner; k=NCORE comes
        // back to the last winner itself, so it only wins when nobody else asks.
        for (int k = 1; k <= NCORE; k++) begin
            for (int j = 0; j < NCORE; j++) begin
                if (!found && (j == ((int'(ptr) + k) % NCORE)) && req[j]) begin
                    win[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// One ALU shared by NCORE requesters. A round-robin pick is made in IDLE,
// the winner's operands are latched at grant, and the result is returned
// with a one-cycle done pulse. MUL spends one extra cycle in MUL2.
//
// state | meaning
// IDLE  | no transaction, waiting for any req
// EXEC  | operands latched; non-MUL result written on leaving
// MUL2  | product written on leaving
// DONE  | done pulses for the granted core, pointer updated
//
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   req             - per-core request, held until done
//   op              - per-core one-hot op, core i at [4i+3:4i]
//   ac/bus_in/mem_id- per-core operands, core i at [WIDTH*i +: WIDTH]
//   gnt             - one-hot grant, capture cycle through done cycle
//   done            - one-cycle completion pulse
//   result          - registered result, held until the next done
//   busy            - FSM not in IDLE
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCORE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCORE-1:0]       req,
    input  logic [NCORE*4-1:0]     op,
    input  logic [NCORE*WIDTH-1:0] ac,
    input  logic [NCORE*WIDTH-1:0] bus_in,
    input  logic [NCORE*WIDTH-1:0] mem_id,
    output logic [NCORE-1:0]       gnt,
    output logic [NCORE-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   busy
);

    localparam int PW = $clog2(NCORE);

    logic [1:0]       state_q, state_d;
    logic [NCORE-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic [WIDTH-1:0] mem_q, mem_d;

    logic [NCORE-1:0] win;
    op_t              op_sel;
    logic [WIDTH-1:0] ac_sel, bus_sel, mem_sel;
    logic [PW-1:0]    gidx;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_res;

    rr_pick #(
        .NCORE (NCORE),
        .PW    (PW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .win (win)
    );

    // Operand mux driven by the one-hot winner.
    always_comb begin
        op_sel  = '0;
        ac_sel  = '0;
        bus_sel = '0;
        mem_sel = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (win[i]) begin
                op_sel  = op[4*i +: 4];
                ac_sel  = ac[WIDTH*i +: WIDTH];
                bus_sel = bus_in[WIDTH*i +: WIDTH];
                mem_sel = mem_id[WIDTH*i +: WIDTH];
            end
        end
    end

    // Index of the currently granted core, used to advance the pointer.
    always_comb begin
        gidx = '0;
        for (int j = 0; j < NCORE; j++) begin
            if (gnt_q[j]) gidx = PW'(j);
        end
    end

    // Anything not exactly one of the single-cycle encodings passes ac through.
    always_comb begin
        case (op_q)
            OP_SET:    alu_res = bus_q;
            OP_ADD:    alu_res = ac_q + bus_q;
            OP_ADDMEM: alu_res = ac_q + mem_q;
            default:   alu_res = ac_q;
        endcase
    end

    assign mul_res = ac_q * bus_q;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        result_d = result_q;
        ptr_d    = ptr_q;
        op_d     = op_q;
        ac_d     = ac_q;
        bus_d    = bus_q;
        mem_d    = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = win;
                    op_d    = op_sel;
                    ac_d    = ac_sel;
                    bus_d   = bus_sel;
                    mem_d   = mem_sel;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_MUL) begin
                    state_d = ST_MUL2;
                end else begin
                    result_d = alu_res;
                    state_d  = ST_DONE;
                end
            end
            ST_MUL2: begin
                result_d = mul_res;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                ptr_d   = gidx;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            result_q <= '0;
            ptr_q    <= PW'(NCORE - 1);
            op_q     <= '0;
            ac_q     <= '0;
            bus_q    <= '0;
            mem_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            result_q <= result_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            ac_q     <= ac_d;
            bus_q    <= bus_d;
            mem_q    <= mem_d;
        end
    end

    // done is decoded from state so a reset removes it immediately.
    assign done   = (state_q == ST_DONE) ? gnt_q : '0;
    assign gnt    = gnt_q;
    assign result = result_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int WIDTH = 8;
    localparam int NCORE = 4;

    logic                   clk;
    logic                   rst_n;
    logic [NCORE-1:0]       req;
    logic [NCORE*4-1:0]     op;
    logic [NCORE*WIDTH-1:0] ac;
    logic [NCORE*WIDTH-1:0] bus_in;
    logic [NCORE*WIDTH-1:0] mem_id;
    logic [NCORE-1:0]       gnt;
    logic [NCORE-1:0]       done;
    logic [WIDTH-1:0]       result;
    logic                   busy;

    alu_share_arbiter #(.WIDTH(WIDTH), .NCORE(NCORE)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .op     (op),
        .ac     (ac),
        .bus_in (bus_in),
        .mem_id (mem_id),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         core;
        logic [3:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] exp;
        int         lat;
        bit         perturb;
        bit         drop;
    } vec_t;

    typedef struct {
        int         core;
        logic [7:0] res;
        int         lat;
    } sb_t;

    vec_t vecs[11];
    sb_t  sb_q[$];
    int   rr_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  cyc;
        int  gcnt;
        bit  got_d;
        sb_t e;
        @(negedge clk);
        op[v.core*4 +: 4]         = v.opc;
        ac[v.core*WIDTH +: WIDTH]     = v.a;
        bus_in[v.core*WIDTH +: WIDTH] = v.b;
        mem_id[v.core*WIDTH +: WIDTH] = v.m;
        req[v.core]               = 1'b1;
        sb_q.push_back('{core: v.core, res: v.exp, lat: v.lat});
        cyc   = 0;
        gcnt  = 0;
        got_d = 0;
        while (!got_d && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (gnt != 0) begin
                gcnt++;
                if (gcnt == 1) begin
                    check("gnt_onehot", 32'(gnt), 32'(1 << v.core));
                    if (v.perturb) begin
                        ac[v.core*WIDTH +: WIDTH]     = 8'hC3;
                        bus_in[v.core*WIDTH +: WIDTH] = 8'h77;
                        mem_id[v.core*WIDTH +: WIDTH] = 8'h5E;
                        op[v.core*4 +: 4]         = 4'b0010;
                    end
                    if (v.drop) req[v.core] = 1'b0;
                end
            end
            if (done != 0) begin
                got_d = 1;
                e = sb_q.pop_front();
                check("done_core", 32'(done), 32'(1 << e.core));
                check("result", 32'(result), 32'(e.res));
                check("gnt_cycles", 32'(gcnt), 32'(e.lat));
                req[v.core] = 1'b0;
            end
        end
        if (!got_d) begin
            check("done_timeout", 32'(cyc), 32'(0));
            void'(sb_q.pop_front());
        end
        @(posedge clk);
        #1;
        check("busy_after", 32'(busy), 32'(0));
        check("gnt_after", 32'(gnt), 32'(0));
        check("result_held", 32'(result), 32'(v.exp));
    endtask

    initial begin
        int cyc;
        int last_done;
        int cur;
        int ngr;
        int ndone;
        logic [NCORE-1:0] prev_gnt;
        bit seen;

        vecs[0]  = '{2, 4'b0100, 8'h05, 8'h03, 8'h00, 8'h08, 2, 0, 0};
        vecs[1]  = '{0, 4'b0010, 8'h10, 8'h11, 8'h00, 8'h10, 3, 0, 0};
        vecs[2]  = '{1, 4'b1000, 8'hFF, 8'h00, 8'h02, 8'h01, 2, 0, 0};
        vecs[3]  = '{1, 4'b0011, 8'h5A, 8'h11, 8'h22, 8'h5A, 2, 0, 0};
        vecs[4]  = '{3, 4'b0001, 8'h12, 8'h34, 8'h56, 8'h34, 2, 0, 0};
        vecs[5]  = '{0, 4'b0000, 8'h77, 8'h01, 8'h02, 8'h77, 2, 0, 0};
        vecs[6]  = '{1, 4'b0010, 8'h0F, 8'h0F, 8'h00, 8'hE1, 3, 0, 0};
        vecs[7]  = '{2, 4'b0100, 8'hFF, 8'h01, 8'h00, 8'h00, 2, 0, 0};
        vecs[8]  = '{3, 4'b1000, 8'h10, 8'h99, 8'h20, 8'h30, 2, 0, 0};
        vecs[9]  = '{3, 4'b0100, 8'h20, 8'h05, 8'h00, 8'h25, 2, 1, 0};
        vecs[10] = '{2, 4'b0010, 8'h03, 8'h07, 8'h00, 8'h15, 3, 0, 1};

        rst_n  = 1'b0;
        req    = '0;
        op     = '0;
        ac     = '0;
        bus_in = '0;
        mem_id = '0;
        #12;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Round robin with all cores requesting continuously from reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NCORE; i++) begin
            op[i*4 +: 4]         = 4'b0001;
            bus_in[i*WIDTH +: WIDTH] = 8'(8'h40 + i);
            ac[i*WIDTH +: WIDTH]     = 8'h00;
        end
        rr_q = '{0, 1, 2, 3, 0};
        req = '1;
        prev_gnt  = '0;
        last_done = -1;
        cur   = 0;
        ngr   = 0;
        ndone = 0;
        cyc   = 0;
        while (ndone < 5 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (gnt != 0 && prev_gnt == 0) begin
                cur = rr_q.pop_front();
                check("rr_order", 32'(gnt), 32'(1 << cur));
                if (ngr > 0) check("rr_gap", 32'(cyc - last_done), 32'(2));
                ngr++;
            end
            if (done != 0) begin
                check("rr_done", 32'(done), 32'(1 << cur));
                check("rr_result", 32'(result), 32'(8'h40 + cur));
                last_done = cyc;
                ndone++;
                if (ndone == 5) req = '0;
            end
            prev_gnt = gnt;
        end
        check("rr_count", 32'(ndone), 32'(5));
        @(posedge clk);
        #1;
        check("rr_idle", 32'(busy), 32'(0));

        // Reset during MUL2 abandons the transaction.
        @(negedge clk);
        op[1*4 +: 4]         = 4'b0010;
        ac[1*WIDTH +: WIDTH]     = 8'h03;
        bus_in[1*WIDTH +: WIDTH] = 8'h05;
        req = 4'b0010;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 6) begin
            @(posedge clk);
            #1;
            cyc++;
            if (gnt != 0) seen = 1;
        end
        check("abort_grant", 32'(gnt), 32'(4'b0010));
        @(posedge clk);
        #2;
        check("abort_busy_mul2", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort_gnt", 32'(gnt), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        op[0*4 +: 4]         = 4'b0001;
        bus_in[0*WIDTH +: WIDTH] = 8'hA0;
        op[3*4 +: 4]         = 4'b0001;
        bus_in[3*WIDTH +: WIDTH] = 8'hA3;
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 6) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done != 0) check("abort_no_done", 32'(done), 32'(0));
            if (gnt != 0) seen = 1;
        end
        check("post_rst_grant", 32'(gnt), 32'(4'b0001));
        req = '0;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done != 0) seen = 1;
        end
        check("post_rst_done", 32'(done), 32'(4'b0001));
        check("post_rst_result", 32'(result), 32'(8'hA0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
